interact_regbank: RTL and testbench
===================================

Name: interact_regbank

Overview:
- Parametrised APF bridge register bank for Pocket cores. Generalises the fixed-map interact controller.
- Provides NUM_REGS 32-bit host-writable registers at a strided address map, plus one command register.
- Optional shadow/commit double-buffering, so multi-register settings apply atomically.
- Per-register change strobes, and a retriggerable core-reset pulse generator with parametrised length and per-register reset-on-update mask.
- Sits between the APF bridge and the core's CDC synchronisers; runs entirely in clk_74a.

Parameters:
- NUM_REGS, 8, number of data registers (1..16).
- BASE_ADDR, 32'hF1000000, address of register 0.
- STRIDE_LOG2, 24, log2 of the byte spacing between registers.
- CMD_ADDR, 32'hF0000000, command/status register address; must not overlap the data map.
- SHADOW, 0, 1 = writes stage until commit; 0 = writes apply directly.
- RESET_MASK, 16'h0001, bit i = 1 means an update to register i triggers core reset.
- RESET_CYCLES, 8000, core_reset_n low duration in clk_74a cycles (>= 1).

Ports:
- clk_74a  in  1  bridge clock
- reset_n  in  1  asynchronous active-low reset
- bridge_addr  in  32  bridge address
- bridge_wr  in  1  write strobe, one cycle
- bridge_wr_data  in  32  write data
- bridge_rd  in  1  read strobe, one cycle
- bridge_rd_data  out  32  read data, registered
- regs_o  out  NUM_REGS*32  committed register values; register i at [32i+31:32i]
- reg_changed  out  NUM_REGS  one-cycle pulse when committed register i changes value
- pending  out  1  at least one staged register is not yet committed (always 0 when SHADOW=0)
- core_reset_n  out  1  active-low core reset pulse

Behaviour:
- Async reset (reset_n low):
  - staged regs, regs_o, reg_changed, pending and bridge_rd_data = 0.
  - Reset counter = 0; core_reset_n = 1.
- Decode:
  - Register i hits when bridge_addr == BASE_ADDR + (i << STRIDE_LOG2), for i < NUM_REGS.
  - CMD_ADDR hits on exact match.
  - Any other address: writes are ignored; reads return 32'h0.
- Write, SHADOW=0:
  - A hit on register i at cycle T sets regs_o[i] = wr_data at T+1.
  - reg_changed[i] pulses at T+1 only if the new value differs from the old one.
  - If RESET_MASK[i] is set, the reset is triggered at T regardless of whether the value changed.
- Write, SHADOW=1:
  - A hit on register i loads staged[i] and sets dirty[i]; regs_o is unchanged.
  - pending = |dirty, registered.
- Command write:
  - bit0 = 1 triggers reset.
  - bit1 = 1 commits: every dirty register copies staged to regs_o at T+1, with reg_changed pulses for the changed ones.
  - The commit clears dirty.
  - If any committed register had RESET_MASK set, reset is triggered.
  - bit1 is ignored when SHADOW=0.
  - bit0 and bit1 together are legal; the commit and the trigger both happen.
- Write to a register in the same cycle as a commit (impossible on a single bridge, but defined): the commit wins; the write is dropped.
- Reset pulse:
  - A trigger at cycle T loads counter = RESET_CYCLES at T+1.
  - core_reset_n = (counter == 0), registered, so it is low from T+1 through T+RESET_CYCLES and high at T+RESET_CYCLES+1.
  - A retrigger while counting reloads the counter, extending the pulse.
  - Counter width = $clog2(RESET_CYCLES+1).
- Read:
  - 1-cycle latency; bridge_rd_data updates at T+1 and holds until the next read.
  - Register i returns staged[i] when SHADOW=1, else regs_o[i].
  - CMD read returns {29'h0, pending, 1'b0, ~core_reset_n}.
  - Read and write in the same cycle to the same address return the pre-write value.
- reg_changed is never asserted for more than one cycle per update event.

Decomposition:
- Package interact_pkg:
  - cmd_bit_e enum (CMD_RESET = 0, CMD_COMMIT = 1).
  - Status bit positions.
  - Function addr_hit(addr, base, stride_log2, idx).
- One sub-module: interact_reset_pulse (params CYCLES; ports clk_74a, reset_n, trigger, core_reset_n, busy).
- Everything else lives in interact_regbank.

Test Plan:
- SHADOW=0: write 32'h12345678 to 32'hF2000000 (reg 1, mask bit 1 = 0) -> regs_o[63:32] = 32'h12345678 next cycle, reg_changed = 8'h02 for exactly 1 cycle, core_reset_n stays 1.
- SHADOW=0, RESET_CYCLES=4: write reg 0 (masked) -> core_reset_n low for exactly 4 cycles. Rewrite after 2 cycles -> low for 6 cycles total. Rewrite of the same value -> reset fires, no reg_changed.
- SHADOW=1:
  - Write regs 2 and 3 -> regs_o unchanged, pending = 1, and readback of 32'hF3000000 returns the staged value.
  - CMD write 32'h2 -> both registers update in the same cycle, reg_changed = 8'h0C, pending = 0.
- Read of unmapped 32'hF9000000 -> rd_data = 0. Read of CMD during reset -> 32'h1; read after reset with pending -> 32'h4.
- reset_n asserted mid-pulse and mid-staging -> all outputs 0 and core_reset_n = 1 immediately (async). After release, a commit with no prior writes produces no change pulses and no reset.

Source files
------------

// File: rtl/interact_pkg.sv
// rtl/interact_pkg.sv - shared types and helpers for the interact register bank
// Purpose: command bit positions, status bit positions and the address
//          decode helper used by interact_regbank.
// Contents:
//   cmd_bit_e         bit positions within a command register write
//   STAT_RESET_BIT    status bit: core reset pulse in progress
//   STAT_PENDING_BIT  status bit: staged registers awaiting commit
//   addr_hit()        strided address match for data register idx
package interact_pkg;

  typedef enum int {
    CMD_RESET  = 0,
    CMD_COMMIT = 1
  } cmd_bit_e;

  localparam int STAT_RESET_BIT   = 0;
  localparam int STAT_PENDING_BIT = 2;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int          stride_log2,
                                    input int          idx);
    logic [31:0] idx_w;
    idx_w = 32'(idx);
    return addr == (base + (idx_w << stride_log2));
  endfunction

endpackage

// File: rtl/interact_reset_pulse.sv
// rtl/interact_reset_pulse.sv - retriggerable core reset pulse generator
// Purpose: drives core_reset_n low for CYCLES clocks after a trigger;
//          a trigger while counting reloads the count and extends the pulse.
// Ports:
//   clk_74a       bridge clock
//   reset_n       asynchronous active-low reset
//   trigger       one-cycle request to (re)start the pulse
//   core_reset_n  active-low pulse, low the cycle after trigger
//   busy          high while the pulse is in progress
module interact_reset_pulse #(
  parameter int CYCLES = 8000
) (
  input  logic clk_74a,
  input  logic reset_n,
  input  logic trigger,
  output logic core_reset_n,
  output logic busy
);

  localparam int             CW   = $clog2(CYCLES + 1);
  localparam logic [CW-1:0]  LOAD = CW'(CYCLES);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (trigger) begin
      cnt_nxt = LOAD;
    end else if (cnt != '0) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  // core_reset_n is registered from the next count so the pulse starts in
  // the same cycle the counter is loaded.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      core_reset_n <= 1'b1;
    end else begin
      cnt          <= cnt_nxt;
      core_reset_n <= (cnt_nxt == '0);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/interact_regbank.sv
// rtl/interact_regbank.sv - parametrised APF bridge register bank
// Purpose: NUM_REGS host-writable 32-bit registers on a strided address map
//          plus a command/status register, optional shadow/commit staging,
//          per-register change strobes and a core reset pulse generator.
// Ports:
//   clk_74a         bridge clock
//   reset_n         asynchronous active-low reset
//   bridge_addr     bridge address
//   bridge_wr       write strobe, one cycle
//   bridge_wr_data  write data
//   bridge_rd       read strobe, one cycle
//   bridge_rd_data  registered read data, held until the next read
//   regs_o          committed registers, register i at [32i+31:32i]
//   reg_changed     one-cycle pulse per committed register whose value changed
//   pending         staged registers awaiting commit (0 when SHADOW=0)
//   core_reset_n    active-low core reset pulse
module interact_regbank
  import interact_pkg::*;
#(
  parameter int          NUM_REGS     = 8,
  parameter logic [31:0] BASE_ADDR    = 32'hF100_0000,
  parameter int          STRIDE_LOG2  = 24,
  parameter logic [31:0] CMD_ADDR     = 32'hF000_0000,
  parameter bit          SHADOW       = 1'b0,
  parameter logic [15:0] RESET_MASK   = 16'h0001,
  parameter int          RESET_CYCLES = 8000
) (
  input  logic                     clk_74a,
  input  logic                     reset_n,
  input  logic [31:0]              bridge_addr,
  input  logic                     bridge_wr,
  input  logic [31:0]              bridge_wr_data,
  input  logic                     bridge_rd,
  output logic [31:0]              bridge_rd_data,
  output logic [NUM_REGS*32-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      reg_changed,
  output logic                     pending,
  output logic                     core_reset_n
);

  localparam logic [NUM_REGS-1:0] MASK = RESET_MASK[NUM_REGS-1:0];

  logic [31:0]         regs    [NUM_REGS];
  logic [31:0]         staged  [NUM_REGS];
  logic [31:0]         upd_val [NUM_REGS];
  logic [NUM_REGS-1:0] hit;
  logic [NUM_REGS-1:0] upd;
  logic [NUM_REGS-1:0] diff;
  logic [NUM_REGS-1:0] dirty;
  logic [NUM_REGS-1:0] dirty_nxt;
  logic                cmd_hit;
  logic                cmd_wr;
  logic                commit;
  logic                trigger;
  logic                rst_busy;
  logic [31:0]         rd_mux;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i] = addr_hit(bridge_addr, BASE_ADDR, STRIDE_LOG2, i);
    end
  end

  assign cmd_hit = (bridge_addr == CMD_ADDR);
  assign cmd_wr  = bridge_wr && cmd_hit;
  assign commit  = SHADOW && cmd_wr && bridge_wr_data[CMD_COMMIT];

  // upd marks the committed registers that load this cycle: direct writes
  // when unshadowed, dirty registers on a commit when shadowed.
  always_comb begin
    upd       = '0;
    diff      = '0;
    dirty_nxt = dirty;
    for (int i = 0; i < NUM_REGS; i++) begin
      upd_val[i] = bridge_wr_data;
      if (SHADOW) begin
        upd_val[i] = staged[i];
        if (commit) begin
          upd[i]       = dirty[i];
          dirty_nxt[i] = 1'b0;
        end else if (bridge_wr && hit[i]) begin
          dirty_nxt[i] = 1'b1;
        end
      end else begin
        upd[i] = bridge_wr && hit[i];
      end
      diff[i] = upd[i] && (upd_val[i] != regs[i]);
    end
  end

  // A masked register reloads the pulse even when rewritten with its old value.
  assign trigger = (cmd_wr && bridge_wr_data[CMD_RESET]) || (|(upd & MASK));

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i]   <= '0;
        staged[i] <= '0;
      end
      dirty       <= '0;
      pending     <= 1'b0;
      reg_changed <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (upd[i]) begin
          regs[i] <= upd_val[i];
        end
        // A commit in the same cycle wins; the concurrent write is dropped.
        if (SHADOW && bridge_wr && hit[i] && !commit) begin
          staged[i] <= bridge_wr_data;
        end
      end
      dirty       <= dirty_nxt;
      pending     <= |dirty_nxt;
      reg_changed <= diff;
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hit[i]) begin
        rd_mux = SHADOW ? staged[i] : regs[i];
      end
    end
    if (cmd_hit) begin
      rd_mux[STAT_PENDING_BIT] = pending;
      rd_mux[STAT_RESET_BIT]   = rst_busy;
    end
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      bridge_rd_data <= '0;
    end else if (bridge_rd) begin
      bridge_rd_data <= rd_mux;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*32 +: 32] = regs[g];
  end

  interact_reset_pulse #(
    .CYCLES (RESET_CYCLES)
  ) u_reset_pulse (
    .clk_74a      (clk_74a),
    .reset_n      (reset_n),
    .trigger      (trigger),
    .core_reset_n (core_reset_n),
    .busy         (rst_busy)
  );

endmodule

// File: tb/tb_interact_regbank.sv
// tb/tb_interact_regbank.sv - scoreboard bench for interact_regbank
module tb_interact_regbank;

  localparam logic [31:0] CMD = 32'hF000_0000;
  localparam logic [31:0] VB  = 32'hBBBB_0002;
  localparam logic [31:0] VX  = 32'h0BAD_F00D;

  logic         clk_74a = 1'b0;
  logic         reset_n = 1'b0;
  logic [31:0]  bridge_addr = '0;
  logic         bridge_wr = 1'b0;
  logic [31:0]  bridge_wr_data = '0;
  logic         bridge_rd = 1'b0;

  logic [31:0]  rd0, rd1;
  logic [255:0] regs0, regs1;
  logic [7:0]   chg0, chg1;
  logic         pend0, pend1, crn0, crn1;

  always #5 clk_74a = ~clk_74a;

  interact_regbank #(.SHADOW(1'b0), .RESET_CYCLES(4)) u_dut0 (
    .clk_74a(clk_74a), .reset_n(reset_n), .bridge_addr(bridge_addr),
    .bridge_wr(bridge_wr), .bridge_wr_data(bridge_wr_data), .bridge_rd(bridge_rd),
    .bridge_rd_data(rd0), .regs_o(regs0), .reg_changed(chg0), .pending(pend0),
    .core_reset_n(crn0));

  interact_regbank #(.SHADOW(1'b1), .RESET_CYCLES(4)) u_dut1 (
    .clk_74a(clk_74a), .reset_n(reset_n), .bridge_addr(bridge_addr),
    .bridge_wr(bridge_wr), .bridge_wr_data(bridge_wr_data), .bridge_rd(bridge_rd),
    .bridge_rd_data(rd1), .regs_o(regs1), .reg_changed(chg1), .pending(pend1),
    .core_reset_n(crn1));

  typedef enum int {O_RD, O_REG, O_CHG, O_PEND, O_CRN} obs_e;
  typedef struct {
    string       tag;
    int          dut;
    obs_e        kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] ra(input int i);
    logic [31:0] iw;
    iw = 32'(i);
    return 32'hF100_0000 + (iw << 24);
  endfunction

  function automatic logic [31:0] observe(input int dut, input obs_e k, input int idx);
    case (k)
      O_RD:    return dut != 0 ? rd1 : rd0;
      O_REG:   return dut != 0 ? regs1[idx*32 +: 32] : regs0[idx*32 +: 32];
      O_CHG:   return dut != 0 ? 32'(chg1) : 32'(chg0);
      O_PEND:  return dut != 0 ? 32'(pend1) : 32'(pend0);
      default: return dut != 0 ? 32'(crn1) : 32'(crn0);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input int dut, input obs_e k,
                         input int idx, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.dut = dut; e.kind = k; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk_74a);
    #1;
    bridge_wr = 1'b0;
    bridge_rd = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("%s[d%0d]", e.tag, e.dut), observe(e.dut, e.kind, e.idx), e.val);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bridge_addr = a; bridge_wr_data = d; bridge_wr = 1'b1;
  endtask

  task automatic rd(input logic [31:0] a);
    bridge_addr = a; bridge_rd = 1'b1;
  endtask

  task automatic chk_cleared(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_rd"},   observe(d, O_RD, 0),   32'h0);
      chk({tag, "_reg0"}, observe(d, O_REG, 0),  32'h0);
      chk({tag, "_reg1"}, observe(d, O_REG, 1),  32'h0);
      chk({tag, "_reg7"}, observe(d, O_REG, 7),  32'h0);
      chk({tag, "_chg"},  observe(d, O_CHG, 0),  32'h0);
      chk({tag, "_pend"}, observe(d, O_PEND, 0), 32'h0);
      chk({tag, "_crn"},  observe(d, O_CRN, 0),  32'h1);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk_74a);
    #1;
    chk_cleared("reset");
    reset_n = 1'b1;
    step();

    // direct write to unmasked reg 1
    wr(ra(1), 32'h1234_5678);
    sb_push("wr1_reg", 0, O_REG, 1, 32'h1234_5678);
    sb_push("wr1_chg", 0, O_CHG, 0, 32'h02);
    sb_push("wr1_crn", 0, O_CRN, 0, 32'h1);
    sb_push("wr1_reg", 1, O_REG, 1, 32'h0);
    sb_push("wr1_pend", 1, O_PEND, 0, 32'h1);
    sb_push("wr1_chg", 1, O_CHG, 0, 32'h0);
    step();
    sb_push("wr1_chg_end", 0, O_CHG, 0, 32'h0);
    sb_push("wr1_crn", 0, O_CRN, 0, 32'h1);
    step();

    // read + write same address returns pre-write value
    wr(ra(1), VX);
    bridge_rd = 1'b1;
    sb_push("rw_rd", 0, O_RD, 0, 32'h1234_5678);
    sb_push("rw_rd", 1, O_RD, 0, 32'h1234_5678);
    sb_push("rw_reg", 0, O_REG, 1, VX);
    sb_push("rw_chg", 0, O_CHG, 0, 32'h02);
    step();

    // masked reg 0: 4-cycle reset pulse, CMD status readback
    wr(ra(0), 32'hAAAA_0001);
    sb_push("p4_crn", 0, O_CRN, 0, 32'h0);
    sb_push("p4_chg", 0, O_CHG, 0, 32'h01);
    sb_push("p4_crn", 1, O_CRN, 0, 32'h1);
    step();
    rd(CMD);
    sb_push("cmd_rd_busy", 0, O_RD, 0, 32'h1);
    sb_push("cmd_rd_pend", 1, O_RD, 0, 32'h4);
    sb_push("p4_crn", 0, O_CRN, 0, 32'h0);
    step();
    repeat (2) begin
      sb_push("p4_crn", 0, O_CRN, 0, 32'h0);
      step();
    end
    sb_push("p4_crn_end", 0, O_CRN, 0, 32'h1);
    step();

    // retrigger after 2 cycles with the same value: 6-cycle pulse, no change
    wr(ra(0), VB);
    sb_push("p6_crn", 0, O_CRN, 0, 32'h0);
    sb_push("p6_chg", 0, O_CHG, 0, 32'h01);
    step();
    sb_push("p6_crn", 0, O_CRN, 0, 32'h0);
    sb_push("p6_chg", 0, O_CHG, 0, 32'h0);
    step();
    wr(ra(0), VB);
    sb_push("p6_crn", 0, O_CRN, 0, 32'h0);
    sb_push("same_chg", 0, O_CHG, 0, 32'h0);
    sb_push("same_reg", 0, O_REG, 0, VB);
    step();
    repeat (3) begin
      sb_push("p6_crn", 0, O_CRN, 0, 32'h0);
      step();
    end
    sb_push("p6_crn_end", 0, O_CRN, 0, 32'h1);
    step();

    // commit staged regs 0 and 1 (reg 0 masked)
    wr(CMD, 32'h2);
    sb_push("c1_chg", 1, O_CHG, 0, 32'h03);
    sb_push("c1_reg0", 1, O_REG, 0, VB);
    sb_push("c1_reg1", 1, O_REG, 1, VX);
    sb_push("c1_pend", 1, O_PEND, 0, 32'h0);
    sb_push("c1_crn", 1, O_CRN, 0, 32'h0);
    sb_push("c1_chg", 0, O_CHG, 0, 32'h0);
    sb_push("c1_crn", 0, O_CRN, 0, 32'h1);
    step();
    repeat (3) begin
      sb_push("c1_crn", 1, O_CRN, 0, 32'h0);
      step();
    end
    sb_push("c1_crn_end", 1, O_CRN, 0, 32'h1);
    step();

    // stage regs 2 and 3, read back staged, then commit atomically
    wr(ra(2), 32'h2222_2222);
    sb_push("s2_chg", 0, O_CHG, 0, 32'h04);
    sb_push("s2_reg", 1, O_REG, 2, 32'h0);
    sb_push("s2_pend", 1, O_PEND, 0, 32'h1);
    step();
    wr(ra(3), 32'h3333_3333);
    sb_push("s3_chg", 0, O_CHG, 0, 32'h08);
    sb_push("s3_reg", 1, O_REG, 3, 32'h0);
    step();
    rd(32'hF300_0000);
    sb_push("staged_rd", 1, O_RD, 0, 32'h2222_2222);
    sb_push("staged_reg", 1, O_REG, 2, 32'h0);
    step();
    wr(CMD, 32'h2);
    sb_push("c2_chg", 1, O_CHG, 0, 32'h0C);
    sb_push("c2_reg2", 1, O_REG, 2, 32'h2222_2222);
    sb_push("c2_reg3", 1, O_REG, 3, 32'h3333_3333);
    sb_push("c2_pend", 1, O_PEND, 0, 32'h0);
    sb_push("c2_crn", 1, O_CRN, 0, 32'h1);
    step();
    sb_push("c2_chg_end", 1, O_CHG, 0, 32'h0);
    step();

    // unmapped address (one past the last register) and the last register
    rd(32'hF900_0000);
    sb_push("unmap_rd", 0, O_RD, 0, 32'h0);
    sb_push("unmap_rd", 1, O_RD, 0, 32'h0);
    step();
    wr(32'hF900_0000, 32'hFFFF_FFFF);
    sb_push("unmap_chg", 0, O_CHG, 0, 32'h0);
    sb_push("unmap_reg0", 0, O_REG, 0, VB);
    sb_push("unmap_pend", 1, O_PEND, 0, 32'h0);
    step();
    wr(ra(7), 32'h0000_0077);
    sb_push("r7_reg", 0, O_REG, 7, 32'h77);
    sb_push("r7_chg", 0, O_CHG, 0, 32'h80);
    sb_push("r7_pend", 1, O_PEND, 0, 32'h1);
    step();

    // async reset mid-pulse and mid-staging
    wr(ra(0), 32'hC0C0_C0C0);
    sb_push("m_crn", 0, O_CRN, 0, 32'h0);
    sb_push("m_crn", 1, O_CRN, 0, 32'h1);
    step();
    wr(CMD, 32'h1);
    sb_push("m_crn", 1, O_CRN, 0, 32'h0);
    sb_push("m_pend", 1, O_PEND, 0, 32'h1);
    step();
    rd(ra(1));
    sb_push("m_rd", 0, O_RD, 0, VX);
    sb_push("m_rd", 1, O_RD, 0, VX);
    step();
    #3;
    reset_n = 1'b0;
    #1;
    chk_cleared("async");
    @(posedge clk_74a);
    #1;
    reset_n = 1'b1;
    step();
    wr(CMD, 32'h2);
    for (int d = 0; d < 2; d++) begin
      sb_push("empty_commit_chg", d, O_CHG, 0, 32'h0);
      sb_push("empty_commit_crn", d, O_CRN, 0, 32'h1);
    end
    sb_push("empty_commit_pend", 1, O_PEND, 0, 32'h0);
    step();
    sb_push("empty_commit_crn", 0, O_CRN, 0, 32'h1);
    sb_push("empty_commit_crn", 1, O_CRN, 0, 32'h1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
